carwash_ctrl_gen: RTL and testbench

//  Next-generation car-wash controller. Internal cycle timers replace the external
//  T1DONE/T2DONE/CLRT1/CLRT2 handshake. Adds a multi-token credit counter, two wash

---
 rtl/carwash_ctrl_gen_if.sv | 25 ++
 rtl/carwash_ctrl_gen.sv | 130 +++++++++++++
 tb/tb_carwash_ctrl_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/carwash_ctrl_gen_if.sv
// Front-panel / valve-driver bundle for the car-wash controller.
// master: panel side (drives TOKEN/START/DELUXE/ESTOP); slave: controller.
interface carwash_ctrl_gen_if #(
  parameter int CREDIT_W = 4
);
  logic                TOKEN;
  logic                START;
  logic                DELUXE;
  logic                ESTOP;
  logic                SPRAY;
  logic                SOAP;
  logic                BUSY;
  logic                DONE;
  logic [CREDIT_W-1:0] CREDIT;

  modport master (
    output TOKEN, START, DELUXE, ESTOP,
    input  SPRAY, SOAP, BUSY, DONE, CREDIT
  );

  modport slave (
    input  TOKEN, START, DELUXE, ESTOP,
    output SPRAY, SOAP, BUSY, DONE, CREDIT
  );
endinterface

// File: rtl/carwash_ctrl_gen.sv
// Car-wash controller: token credit, BASIC/DELUXE programs, internal phase timers, ESTOP.
// Ports: clk, CLR_N (sync active-low), bus (slave: panel inputs, valve/status outputs).
module carwash_ctrl_gen #(
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 15,
  parameter int BASIC_COST  = 1,
  parameter int DELUXE_COST = 2,
  parameter int TIMER_W     = 16,
  parameter int PRE_CYC     = 8,
  parameter int SOAP_CYC    = 6,
  parameter int RINSE_CYC   = 8
) (
  input logic               clk,
  input logic               CLR_N,
  carwash_ctrl_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PRE, SOAPING, RINSE, HALT
  } st_t;

  localparam logic [TIMER_W-1:0] PRE_L   = TIMER_W'(PRE_CYC - 1);
  localparam logic [TIMER_W-1:0] SOAP_L  = TIMER_W'(SOAP_CYC - 1);
  localparam logic [TIMER_W-1:0] RINSE_L = TIMER_W'(RINSE_CYC - 1);
  localparam logic [CREDIT_W-1:0] BC  = CREDIT_W'(BASIC_COST);
  localparam logic [CREDIT_W-1:0] DC  = CREDIT_W'(DELUXE_COST);
  localparam logic [CREDIT_W-1:0] MAX = CREDIT_W'(MAX_CREDIT);

  st_t                 st, st_nx;
  logic [TIMER_W-1:0]  tmr, tmr_nx;
  logic [CREDIT_W-1:0] cred, cred_nx;
  logic [CREDIT_W-1:0] cost, sum;
  logic                done_q, done_nx;
  logic                acc;

  always_ff @(posedge clk) begin
    if (!CLR_N) begin
      st     <= IDLE;
      tmr    <= '0;
      cred   <= '0;
      done_q <= 1'b0;
    end else begin
      st     <= st_nx;
      tmr    <= tmr_nx;
      cred   <= cred_nx;
      done_q <= done_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    tmr_nx  = tmr;
    done_nx = 1'b0;
    acc     = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.START && !bus.ESTOP) begin
          if (bus.DELUXE && cred >= DC) begin
            st_nx  = PRE;
            tmr_nx = PRE_L;
            acc    = 1'b1;
          end else if (!bus.DELUXE && cred >= BC) begin
            st_nx  = RINSE;
            tmr_nx = RINSE_L;
            acc    = 1'b1;
          end
        end
      end
      PRE: begin
        if (bus.ESTOP) begin
          st_nx  = HALT;
          tmr_nx = '0;
        end else if (tmr == '0) begin
          st_nx  = SOAPING;
          tmr_nx = SOAP_L;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      SOAPING: begin
        if (bus.ESTOP) begin
          st_nx  = HALT;
          tmr_nx = '0;
        end else if (tmr == '0) begin
          st_nx  = RINSE;
          tmr_nx = RINSE_L;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      RINSE: begin
        if (bus.ESTOP) begin
          st_nx  = HALT;
          tmr_nx = '0;
        end else if (tmr == '0) begin
          st_nx   = IDLE;
          done_nx = 1'b1;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      HALT: begin
        if (!bus.ESTOP) st_nx = IDLE;
      end
      default: begin
        st_nx  = IDLE;
        tmr_nx = '0;
      end
    endcase
  end

  // Saturate first, then charge: acceptance was judged on the old credit,
  // so the subtraction can never underflow.
  always_comb begin
    cost = '0;
    if (acc) cost = bus.DELUXE ? DC : BC;
    sum = cred;
    if (bus.TOKEN && cred != MAX) sum = cred + 1'b1;
    cred_nx = sum - cost;
  end

  always_comb begin
    bus.SPRAY  = (st == PRE) || (st == RINSE);
    bus.SOAP   = (st == SOAPING);
    bus.BUSY   = (st != IDLE);
    bus.DONE   = done_q;
    bus.CREDIT = cred;
  end

endmodule

// File: tb/tb_carwash_ctrl_gen.sv
// Randomized bench for carwash_ctrl_gen against a per-cycle valve schedule model.
// Model: accepted START enqueues one {spray,soap} entry per wash cycle.
module tb_carwash_ctrl_gen;

  logic clk;
  logic CLR_N;
  int   n_checks;
  int   n_errors;

  carwash_ctrl_gen_if #(.CREDIT_W(4)) bus ();

  carwash_ctrl_gen dut (
    .clk   (clk),
    .CLR_N (CLR_N),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [1:0] sched[$];
  bit         m_halt;
  bit         m_done;
  int         m_cred;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit busy;
    bit acc;
    int cost;
    busy = (sched.size() > 0) || m_halt;
    if (!CLR_N) begin
      sched.delete();
      m_halt = 0;
      m_done = 0;
      m_cred = 0;
    end else begin
      cost = bus.DELUXE ? 2 : 1;
      acc  = !busy && bus.START && !bus.ESTOP && (m_cred >= cost);
      m_cred = m_cred + (bus.TOKEN ? 1 : 0);
      if (m_cred > 15) m_cred = 15;
      if (acc) m_cred -= cost;
      m_done = 0;
      if (m_halt) begin
        if (!bus.ESTOP) m_halt = 0;
      end else if (sched.size() > 0) begin
        if (bus.ESTOP) begin
          sched.delete();
          m_halt = 1;
        end else begin
          void'(sched.pop_front());
          if (sched.size() == 0) m_done = 1;
        end
      end else if (acc) begin
        if (bus.DELUXE) begin
          repeat (8) sched.push_back(2'b10);
          repeat (6) sched.push_back(2'b01);
        end
        repeat (8) sched.push_back(2'b10);
      end
    end
  end

  task automatic check_all();
    logic [1:0] v;
    v = (sched.size() > 0) ? sched[0] : 2'b00;
    chk("spray",  int'(bus.SPRAY),  int'(v[1]));
    chk("soap",   int'(bus.SOAP),   int'(v[0]));
    chk("busy",   int'(bus.BUSY),   int'((sched.size() > 0) || m_halt));
    chk("done",   int'(bus.DONE),   int'(m_done));
    chk("credit", int'(bus.CREDIT), m_cred);
  endtask

  initial begin
    int estop_hold;
    int rst_hold;
    int done_seen;
    n_checks   = 0;
    n_errors   = 0;
    estop_hold = 0;
    rst_hold   = 0;
    done_seen  = 0;
    CLR_N      = 1'b0;
    bus.TOKEN  = 1'b1;
    bus.START  = 1'b0;
    bus.DELUXE = 1'b0;
    bus.ESTOP  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_credit", int'(bus.CREDIT), 0);
    chk("rst_busy",   int'(bus.BUSY),   0);
    chk("rst_spray",  int'(bus.SPRAY),  0);
    chk("rst_done",   int'(bus.DONE),   0);
    bus.TOKEN = 1'b0;
    CLR_N     = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      check_all();
      if (bus.DONE) done_seen++;
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 199) == 0) rst_hold = $urandom_range(1, 2);
      CLR_N = (rst_hold == 0);
      if (estop_hold > 0) estop_hold--;
      else if ($urandom_range(0, 39) == 0) estop_hold = $urandom_range(1, 6);
      bus.ESTOP = (estop_hold > 0);
      if (cyc >= 200 && cyc < 225) begin
        bus.TOKEN = 1'b1;
        bus.START = 1'b0;
      end else begin
        bus.TOKEN = ($urandom_range(0, 9) < 3);
        bus.START = ($urandom_range(0, 9) < 2);
      end
      bus.DELUXE = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    check_all();
    chk("done_seen", int'(done_seen > 0), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
